// File: rtl/mix_col_seq_pkg.sv
// Shared definitions for the MixColumns sequencer: FSM encoding, widths, byte access.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: state_t (IDLE/FEED/WAIT/DONE), AES_STATE_W, BYTE_W, COL_W, state_byte().
package mix_col_seq_pkg;

    localparam int AES_STATE_W = 128;
    localparam int BYTE_W      = 8;
    localparam int COL_W       = 4 * BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte k of a column-major state; byte 0 sits in the top bits.
    // A left shift avoids a variable part-select and keeps widths exact.
    function automatic logic [BYTE_W-1:0] state_byte(input logic [AES_STATE_W-1:0] s,
                                                     input logic [3:0]             k);
        logic [AES_STATE_W-1:0] sh;
        sh = s << {k, 3'b000};
        return sh[AES_STATE_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/mix_col_seq.sv
// Sequencer feeding a byte-serial MixColumns datapath and reassembling the transformed state.
// Latency: out_valid 4*(4+MC_LAT)+1 cycles after the accept edge (21 for MC_LAT=1).
// Backpressure: in_ready high only in IDLE; result held in DONE until out_ready.
// Ports: clk/rst (async, active high); in_valid/in_ready/in_state/in_mode (request);
//        mc_d_out/mc_en/mc_mode (to datapath); mc_d0_in..mc_d3_in (column result rows 0..3);
//        out_valid/out_ready/out_state (response, same byte layout as in_state).
module mix_col_seq
    import mix_col_seq_pkg::*;
#(
    parameter int MC_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_mode,
    output logic [BYTE_W-1:0]      mc_d_out,
    output logic                   mc_en,
    output logic                   mc_mode,
    input  logic [BYTE_W-1:0]      mc_d0_in,
    input  logic [BYTE_W-1:0]      mc_d1_in,
    input  logic [BYTE_W-1:0]      mc_d2_in,
    input  logic [BYTE_W-1:0]      mc_d3_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam logic [1:0] LAT_LAST = 2'(MC_LAT - 1);

    state_t                 state;
    logic [AES_STATE_W-1:0] src;
    logic [1:0]             beat;
    logic [1:0]             col;
    logic [1:0]             lat;

    // All outputs are registered: mc_en/mc_d_out describe the beat presented in the
    // current cycle, so each transition loads the value for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            src       <= '0;
            beat      <= '0;
            col       <= '0;
            lat       <= '0;
            in_ready  <= 1'b0;
            mc_en     <= 1'b0;
            mc_d_out  <= '0;
            mc_mode   <= 1'b0;
            out_valid <= 1'b0;
            out_state <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        src      <= in_state;
                        mc_mode  <= in_mode;
                        col      <= 2'd0;
                        beat     <= 2'd0;
                        in_ready <= 1'b0;
                        mc_en    <= 1'b1;
                        mc_d_out <= state_byte(in_state, 4'd0);
                        state    <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (beat == 2'd3) begin
                        mc_en    <= 1'b0;
                        mc_d_out <= '0;
                        lat      <= 2'd0;
                        state    <= ST_WAIT;
                    end else begin
                        beat     <= beat + 2'd1;
                        mc_d_out <= state_byte(src, {col, beat + 2'd1});
                    end
                end
                ST_WAIT: begin
                    if (lat == LAT_LAST) begin
                        // Result has settled: store it into this column's slot.
                        for (int c = 0; c < 4; c++) begin
                            if (col == c[1:0]) begin
                                out_state[AES_STATE_W-1-COL_W*c -: COL_W] <=
                                    {mc_d0_in, mc_d1_in, mc_d2_in, mc_d3_in};
                            end
                        end
                        if (col == 2'd3) begin
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            col      <= col + 2'd1;
                            beat     <= 2'd0;
                            mc_en    <= 1'b1;
                            mc_d_out <= state_byte(src, {col + 2'd1, 2'd0});
                            state    <= ST_FEED;
                        end
                    end else begin
                        lat <= lat + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_col_seq.sv
// Bench for mix_col_seq: two builds (MC_LAT=1 and MC_LAT=3), each wired to a
// byte-serial MixColumns reference that presents its result exactly MC_LAT cycles
// after the last beat of a column and drives zeros before that.
module tb_mix_col_seq;

    logic         clk;
    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_state  [2];
    logic         in_mode   [2];
    logic [7:0]   mc_d_out  [2];
    logic         mc_en     [2];
    logic         mc_mode   [2];
    logic [7:0]   mc_d0_in  [2];
    logic [7:0]   mc_d1_in  [2];
    logic [7:0]   mc_d2_in  [2];
    logic [7:0]   mc_d3_in  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_state [2];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a [4];
        logic [7:0] k [4];
        logic [7:0] r [4];
        a[0] = c[31:24]; a[1] = c[23:16]; a[2] = c[15:8]; a[3] = c[7:0];
        if (inv) begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        for (int row = 0; row < 4; row++) begin
            r[row] = 8'h00;
            for (int j = 0; j < 4; j++) r[row] = r[row] ^ gmul(a[j], k[(j - row + 4) % 4]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        localparam int LAT = (i == 0) ? 1 : 3;

        mix_col_seq #(.MC_LAT(LAT)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[i]),
            .in_ready (in_ready[i]),
            .in_state (in_state[i]),
            .in_mode  (in_mode[i]),
            .mc_d_out (mc_d_out[i]),
            .mc_en    (mc_en[i]),
            .mc_mode  (mc_mode[i]),
            .mc_d0_in (mc_d0_in[i]),
            .mc_d1_in (mc_d1_in[i]),
            .mc_d2_in (mc_d2_in[i]),
            .mc_d3_in (mc_d3_in[i]),
            .out_valid(out_valid[i]),
            .out_ready(out_ready[i]),
            .out_state(out_state[i])
        );

        logic [7:0]  sh [4];
        logic [1:0]  cnt;
        logic [1:0]  dly;
        logic [31:0] res;
        logic        ok;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= 2'd0; dly <= 2'd0; res <= 32'h0; ok <= 1'b0;
            end else if (mc_en[i]) begin
                ok <= 1'b0;
                if (cnt == 2'd3) begin
                    res <= mix_col({sh[0], sh[1], sh[2], mc_d_out[i]}, mc_mode[i]);
                    dly <= 2'(LAT - 1);
                    ok  <= (LAT == 1);
                    cnt <= 2'd0;
                end else begin
                    sh[cnt] <= mc_d_out[i];
                    cnt     <= cnt + 2'd1;
                end
            end else if (dly != 2'd0) begin
                dly <= dly - 2'd1;
                if (dly == 2'd1) ok <= 1'b1;
            end
        end

        assign mc_d0_in[i] = ok ? res[31:24] : 8'h00;
        assign mc_d1_in[i] = ok ? res[23:16] : 8'h00;
        assign mc_d2_in[i] = ok ? res[15:8]  : 8'h00;
        assign mc_d3_in[i] = ok ? res[7:0]   : 8'h00;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one state on build sel, count cycles to out_valid and mc_en beats,
    // optionally complete the output handshake.
    task automatic run_xfer(input int sel, input logic [127:0] st, input logic md, input bit hs,
                            output int ovc, output int nb, output logic [127:0] res);
        chk("in_ready_pre", 128'(in_ready[sel]), 128'(1'b1));
        in_valid[sel] = 1'b1; in_state[sel] = st; in_mode[sel] = md;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0; in_state[sel] = {4{$urandom}}; in_mode[sel] = ~md;
        ovc = 0; nb = 0;
        for (int n = 1; n < 200; n++) begin
            if (out_valid[sel]) begin ovc = n; break; end
            if (mc_en[sel]) nb++;
            else chk("d_out_zero", 128'(mc_d_out[sel]), 128'(8'h00));
            chk("mc_mode_hold", 128'(mc_mode[sel]), 128'(md));
            chk("in_ready_busy", 128'(in_ready[sel]), 128'(1'b0));
            @(posedge clk); #1;
        end
        chk("out_valid_seen", 128'(out_valid[sel]), 128'(1'b1));
        res = out_state[sel];
        if (hs) begin
            out_ready[sel] = 1'b1;
            @(posedge clk); #1;
            out_ready[sel] = 1'b0;
            chk("in_ready_after", 128'(in_ready[sel]), 128'(1'b1));
            chk("out_valid_drop", 128'(out_valid[sel]), 128'(1'b0));
        end
    endtask

    localparam logic [127:0] S_FWD  = {4{32'hdb135345}};
    localparam logic [127:0] R_FWD  = {4{32'h8e4da1bc}};
    localparam logic [127:0] S_F2   = {4{32'hf20a225c}};
    localparam logic [127:0] R_F2   = {4{32'h9fdc589d}};
    localparam logic [127:0] S_MIX  = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [127:0] R_MIX  = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [127:0] S_INV  = {32'h8e4da1bc, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [127:0] S_SEQ  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int           ovc;
        int           nb;
        int           acc;
        logic [127:0] res;
        logic [127:0] exp_inv;
        logic [127:0] snap;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_state[i] = '0; in_mode[i] = 1'b0; out_ready[i] = 1'b0;
        end

        // Reset values
        #12;
        chk("rst_in_ready", 128'(in_ready[0]), 128'(1'b0));
        chk("rst_mc_en", 128'(mc_en[0]), 128'(1'b0));
        chk("rst_mc_d_out", 128'(mc_d_out[0]), 128'(8'h00));
        chk("rst_mc_mode", 128'(mc_mode[0]), 128'(1'b0));
        chk("rst_out_valid", 128'(out_valid[0]), 128'(1'b0));
        chk("rst_out_state", out_state[0], 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready_rel", 128'(in_ready[0]), 128'(1'b1));
        chk("rst_in_ready_rel3", 128'(in_ready[1]), 128'(1'b1));

        // 1: forward, MC_LAT=1
        run_xfer(0, S_FWD, 1'b0, 1'b1, ovc, nb, res);
        chk("t1_out_state", res, R_FWD);
        chk("t1_ov_cycle", 128'(ovc), 128'(21));
        chk("t1_beats", 128'(nb), 128'(16));

        // 2: inverse
        exp_inv = {32'hdb135345, mix_col(32'hf20a225c, 1'b1), 32'h01010101, 32'hc6c6c6c6};
        run_xfer(0, S_INV, 1'b1, 1'b1, ovc, nb, res);
        chk("t2_out_state", res, exp_inv);
        chk("t2_ov_cycle", 128'(ovc), 128'(21));

        // 3: backpressure for 10 cycles
        run_xfer(0, S_MIX, 1'b0, 1'b0, ovc, nb, res);
        chk("t3_out_state", res, R_MIX);
        snap = out_state[0];
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            chk("t3_hold_state", out_state[0], snap);
            chk("t3_hold_valid", 128'(out_valid[0]), 128'(1'b1));
            chk("t3_hold_in_ready", 128'(in_ready[0]), 128'(1'b0));
            chk("t3_hold_mc_en", 128'(mc_en[0]), 128'(1'b0));
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("t3_in_ready_after", 128'(in_ready[0]), 128'(1'b1));
        chk("t3_out_valid_drop", 128'(out_valid[0]), 128'(1'b0));

        // 4: in_valid held high, mode and state toggling while busy
        acc = 0;
        in_valid[0] = 1'b1; in_state[0] = S_INV; in_mode[0] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (in_valid[0] && in_ready[0]) acc++;
            @(posedge clk); #1;
            in_mode[0]  = ~in_mode[0];
            in_state[0] = {4{$urandom}};
            if (mc_mode[0] !== 1'b1) chk("t4_mc_mode", 128'(mc_mode[0]), 128'(1'b1));
            if (out_valid[0]) break;
        end
        in_valid[0] = 1'b0;
        chk("t4_out_valid", 128'(out_valid[0]), 128'(1'b1));
        chk("t4_accepts", 128'(acc), 128'(1));
        chk("t4_mc_mode_end", 128'(mc_mode[0]), 128'(1'b1));
        chk("t4_out_state", out_state[0], exp_inv);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("t4_in_ready_after", 128'(in_ready[0]), 128'(1'b1));

        // 5: reset during column 2 beat 1 (cycle 12)
        in_valid[0] = 1'b1; in_state[0] = S_SEQ; in_mode[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int n = 1; n < 12; n++) begin
            @(posedge clk); #1;
        end
        chk("t5_pre_mc_en", 128'(mc_en[0]), 128'(1'b1));
        chk("t5_pre_d_out", 128'(mc_d_out[0]), 128'(8'h99));
        chk("t5_pre_partial", 128'(out_state[0][127:64]), 128'(mix_col(32'h00112233, 1'b1)) << 32
            | 128'(mix_col(32'h44556677, 1'b1)));
        rst = 1'b1;
        #1;
        chk("t5_rst_mc_en", 128'(mc_en[0]), 128'(1'b0));
        chk("t5_rst_d_out", 128'(mc_d_out[0]), 128'(8'h00));
        chk("t5_rst_mc_mode", 128'(mc_mode[0]), 128'(1'b0));
        chk("t5_rst_in_ready", 128'(in_ready[0]), 128'(1'b0));
        chk("t5_rst_out_valid", 128'(out_valid[0]), 128'(1'b0));
        chk("t5_rst_out_state", out_state[0], 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("t5_no_beat", 128'(mc_en[0]), 128'(1'b0));
        end
        // out_ready already high before out_valid must not disturb the transfer
        out_ready[0] = 1'b1;
        run_xfer(0, S_F2, 1'b0, 1'b1, ovc, nb, res);
        chk("t5_out_state", res, R_F2);
        chk("t5_ov_cycle", 128'(ovc), 128'(21));
        chk("t5_beats", 128'(nb), 128'(16));

        // 6: MC_LAT=3 build repeats test 1
        run_xfer(1, S_FWD, 1'b0, 1'b1, ovc, nb, res);
        chk("t6_out_state", res, R_FWD);
        chk("t6_ov_cycle", 128'(ovc), 128'(29));
        chk("t6_beats", 128'(nb), 128'(16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
